// File: rtl/bit_demux_pkg.sv
// Shared constants for the sequential bit demultiplexer: FSM state codes and
// the scan/addressed mode encoding.
package bit_demux_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/demux_dec.sv
// Combinational one-hot decoder: binary index to N-bit one-hot, with a flag
// telling whether the index addresses a real output.
module demux_dec #(
  parameter int unsigned N     = 8,
  parameter int unsigned Log2N = 3
) (
  input  logic [Log2N-1:0] idx_i,
  output logic [N-1:0]     onehot_o,
  output logic             in_range_o
);

  always_comb begin
    onehot_o   = '0;
    in_range_o = (32'(idx_i) < N);
    for (int i = 0; i < int'(N); i++) begin
      if (idx_i == Log2N'(i)) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_demux_seq.sv
// Sequential 1-to-N bit demultiplexer: scatters serial bits into an N-bit word,
// addressed by sel_i or by an internal scan counter, and presents it with a pulse.
module bit_demux_seq
  import bit_demux_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned Log2N = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  input  logic [Log2N-1:0] sel_i,
  output logic [N-1:0]     data_o,
  output logic             data_valid_o,
  output logic             busy_o,
  output logic             err_sel_o
);

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     data_q, data_d;
  logic [Log2N-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [Log2N-1:0] wr_idx;
  logic [N-1:0]     wr_onehot;
  logic             wr_in_range;
  logic [N-1:0]     shadow_wr;
  logic [N-1:0]     mask_wr;
  logic             complete;

  assign wr_idx = (mode_q == MODE_SCAN) ? cnt_q : sel_i;

  demux_dec #(
    .N    (N),
    .Log2N(Log2N)
  ) u_dec (
    .idx_i     (wr_idx),
    .onehot_o  (wr_onehot),
    .in_range_o(wr_in_range)
  );

  // Out-of-range indices decode to all-zero, so shadow/mask are left untouched.
  assign shadow_wr = (shadow_q & ~wr_onehot) | (wr_onehot & {N{bit_i}});
  assign mask_wr   = mask_q | wr_onehot;
  assign complete  = (mode_q == MODE_SCAN) ? (cnt_q == Log2N'(N - 1)) : (&mask_wr);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    if (start_i) begin
      // Start clears the word in every state; data_q is deliberately kept.
      mode_d   = mode_i;
      shadow_d = '0;
      mask_d   = '0;
      cnt_d    = '0;
      err_d    = 1'b0;
      state_d  = StFill;
    end else begin
      case (state_q)
        StIdle: state_d = StIdle;
        StFill: begin
          if (bit_valid_i) begin
            if (wr_in_range) begin
              shadow_d = shadow_wr;
              mask_d   = mask_wr;
              if (mode_q == MODE_SCAN) begin
                cnt_d = cnt_q + 1'b1;
              end
              if (complete) begin
                data_d  = shadow_wr;
                state_d = StDone;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      mode_q   <= MODE_ADDR;
      shadow_q <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = (state_q == StDone);
  assign busy_o       = (state_q == StFill);
  assign err_sel_o    = err_q;

endmodule
